// File: rtl/spi_byte_master.sv
// Single-byte SPI mode-0 master: MSB first, runtime SCLK half-period, busy/avail handshake.
module spi_byte_master (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        start,
    input  logic [25:0] div_factor,
    output logic        mosi,
    output logic        sclk,
    output logic        cs,
    output logic [7:0]  data_out,
    output logic        busy,
    output logic        avail
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 26;
    localparam int unsigned HALF_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE,
        ST_RELEASE
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   r_byte;
    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    r_cnt;
    logic [HALF_W-1:0]   r_half;
    logic                r_mosi;
    logic                r_sclk;
    logic                r_cs;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_busy;
    logic                r_avail;

    logic [DIV_W-1:0]    w_div_eff;
    logic                w_half_end;
    logic                w_last_half;

    // A zero divider behaves as one clk per half-period
    assign w_div_eff   = (div_factor == '0) ? DIV_W'(1) : div_factor;
    assign w_half_end  = (r_cnt == (r_div - DIV_W'(1)));
    assign w_last_half = (r_half == HALF_W'(15));

    // Transfer sequencer: latches the byte, paces SCLK, shifts MOSI on falling edges
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_byte     <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_half     <= '0;
            r_mosi     <= 1'b0;
            r_sclk     <= 1'b0;
            r_cs       <= 1'b1;
            r_data_out <= '0;
            r_busy     <= 1'b0;
            r_avail    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift <= data_in;
                        r_byte  <= data_in;
                        r_div   <= w_div_eff;
                        r_cnt   <= '0;
                        r_half  <= '0;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_sclk  <= 1'b0;
                        r_mosi  <= data_in[DATA_W-1];
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_half_end) begin
                        r_cnt  <= '0;
                        r_half <= r_half + HALF_W'(1);
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else if (w_last_half) begin
                            r_sclk     <= 1'b0;
                            r_cs       <= 1'b1;
                            r_mosi     <= 1'b0;
                            r_avail    <= 1'b1;
                            r_data_out <= r_byte;
                            r_state    <= ST_DONE;
                        end else begin
                            r_sclk  <= 1'b0;
                            r_mosi  <= r_shift[DATA_W-2];
                            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                ST_DONE: begin
                    r_avail <= 1'b0;
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // start must drop before another transfer can be accepted
                    if (!start) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mosi     = r_mosi;
    assign sclk     = r_sclk;
    assign cs       = r_cs;
    assign data_out = r_data_out;
    assign busy     = r_busy;
    assign avail    = r_avail;

endmodule

// File: tb/tb_spi_byte_master.sv
// Scoreboard bench for spi_byte_master: stimulus queues expected bytes, a monitor decodes the pins.
module tb_spi_byte_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        start;
    logic [25:0] div_factor;
    logic        mosi;
    logic        sclk;
    logic        cs;
    logic [7:0]  data_out;
    logic        busy;
    logic        avail;

    spi_byte_master dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .start      (start),
        .div_factor (div_factor),
        .mosi       (mosi),
        .sclk       (sclk),
        .cs         (cs),
        .data_out   (data_out),
        .busy       (busy),
        .avail      (avail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: reconstruct each transfer from the pins and score it on avail
    logic       prev_sclk  = 1'b0;
    logic       prev_cs    = 1'b1;
    logic       prev_avail = 1'b0;
    int         cs_len     = 0;
    int         nrise      = 0;
    int         since_rise = 0;
    logic [7:0] cap        = 8'h00;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (reset) begin
            cs_len     = 0;
            nrise      = 0;
            since_rise = 0;
            cap        = 8'h00;
            prev_sclk  = 1'b0;
            prev_cs    = 1'b1;
            prev_avail = 1'b0;
        end else begin
            if (!cs) begin
                if (prev_cs) begin
                    cs_len     = 0;
                    nrise      = 0;
                    since_rise = 0;
                    cap        = 8'h00;
                end
                cs_len++;
                since_rise++;
            end
            if (sclk && !prev_sclk) begin
                check("rise_with_cs_low", 32'(cs), 32'd0);
                cap = {cap[6:0], mosi};
                if (exp_q.size() > 0) begin
                    if (nrise == 0)
                        check("first_rise_delay", cs_len, exp_q[0].d + 1);
                    else
                        check("rise_spacing", since_rise, 2 * exp_q[0].d);
                end
                nrise++;
                since_rise = 0;
            end
            if (avail) begin
                check("avail_single_cycle", 32'(prev_avail), 32'd0);
                check("busy_in_done", 32'(busy), 32'd1);
                check("cs_in_done", 32'(cs), 32'd1);
                check("sclk_in_done", 32'(sclk), 32'd0);
                check("mosi_in_done", 32'(mosi), 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_avail: got avail=1 expected no transfer pending (t=%0t)", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("mosi_bits", 32'(cap), 32'(mon_e.data));
                    check("data_out", 32'(data_out), 32'(mon_e.data));
                    check("cs_low_cycles", cs_len, 16 * mon_e.d);
                    check("rise_count", nrise, 8);
                end
            end
            prev_sclk  = sclk;
            prev_cs    = cs;
            prev_avail = avail;
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic launch(input logic [7:0] b, input logic [25:0] div);
        exp_t e;
        wait_idle();
        data_in    = b;
        div_factor = div;
        start      = 1'b1;
        e.data     = b;
        e.d        = (div == 26'd0) ? 1 : int'(div);
        exp_q.push_back(e);
    endtask

    task automatic wait_avail(input bit scramble, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (avail) begin
                ok = 1'b1;
                break;
            end
            if (scramble) begin
                data_in    = 8'($urandom);
                div_factor = 26'($urandom_range(0, 7));
            end
        end
        if (!ok) check("avail_timeout", 32'd0, 32'd1);
    endtask

    task automatic xfer(input logic [7:0] b, input logic [25:0] div);
        bit ok;
        launch(b, div);
        wait_avail(1'b1, ok);
        start = 1'b0;
        if (ok) begin
            @(negedge clk);
            @(negedge clk);
            check("busy_release", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        bit ok;
        int r;
        logic ps;

        reset      = 1'b1;
        start      = 1'b0;
        data_in    = 8'h00;
        div_factor = 26'd0;
        repeat (3) @(negedge clk);
        check("reset_cs", 32'(cs), 32'd1);
        check("reset_sclk", 32'(sclk), 32'd0);
        check("reset_mosi", 32'(mosi), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_avail", 32'(avail), 32'd0);
        check("reset_data_out", 32'(data_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        xfer(8'hA5, 26'd2);
        xfer(8'h0C, 26'd0);

        // start held high through completion must not retrigger
        launch(8'h01, 26'd1);
        wait_avail(1'b0, ok);
        repeat (30) @(negedge clk);
        check("no_retrigger_busy", 32'(busy), 32'd1);
        check("no_retrigger_cs", 32'(cs), 32'd1);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("no_retrigger_release", 32'(busy), 32'd0);
        xfer(8'h01, 26'd1);

        // abort with reset on the 3rd rising sclk edge
        launch(8'hFF, 26'd2);
        r  = 0;
        ps = 1'b0;
        for (int t = 0; t < 500 && r < 3; t++) begin
            @(negedge clk);
            if (sclk && !ps) r++;
            ps = sclk;
        end
        check("abort_reached_third_rise", r, 3);
        reset = 1'b1;
        start = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("abort_cs", 32'(cs), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_avail", 32'(avail), 32'd0);
        check("abort_mosi", 32'(mosi), 32'd0);
        check("abort_data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        xfer(8'h0F, 26'd1);

        // back-to-back with start dropped on avail
        xfer(8'h01, 26'd3);
        xfer(8'h3C, 26'd3);

        repeat (20) xfer(8'($urandom), 26'($urandom_range(0, 4)));

        for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
